// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file port scheduler: default widths,
// regfile mode encoding and the scheduler state encoding.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic RF_MODE_READ  = 1'b0;
  localparam logic RF_MODE_WRITE = 1'b1;

  // Requester indices on the two-way arbiter.
  localparam int REQ_RD = 0;
  localparam int REQ_WR = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_RD_C = 3'd3,
    ST_WR   = 3'd4
  } sched_state_e;

endpackage

// File: rtl/regfile_port_sched_if.sv
// Bundle of the operand-read client, write client and regfile port signals
// handled by the scheduler. The slave modport is the scheduler's view.
interface regfile_port_sched_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              rd_ack;
  logic              rd_done;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  logic [ADDR_W-1:0] rf_address;
  logic              rf_mode;
  logic              rf_write_enable;
  logic [DATA_W-1:0] rf_write_data;
  logic [DATA_W-1:0] rf_out;

  modport slave (
    input  rd_req, rd_addr_a, rd_addr_b, wr_req, wr_addr, wr_data, rf_out,
    output rd_ack, rd_done, rd_data_a, rd_data_b, wr_ack,
           rf_address, rf_mode, rf_write_enable, rf_write_data
  );

  modport master (
    output rd_req, rd_addr_a, rd_addr_b, wr_req, wr_addr, wr_data, rf_out,
    input  rd_ack, rd_done, rd_data_a, rd_data_b, wr_ack,
           rf_address, rf_mode, rf_write_enable, rf_write_data
  );

endinterface

// File: rtl/regfile_port_sched_rr_arb2.sv
// Two-way round-robin arbiter. A single request always wins; on a tie the
// requester not granted last wins. The history bit only moves when the
// consumer signals that the grant is taken (advance).
module rr_arb2 #(
  parameter logic RESET_LAST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant_r;
  logic [1:0] grant_s;

  // Pick the winner from the current requests and the grant history.
  always_comb begin
    grant_s = 2'b00;
    case (req)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = last_grant_r ? 2'b01 : 2'b10;
      default: grant_s = 2'b00;
    endcase
  end

  // Remember which requester took the most recent grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_r <= RESET_LAST;
    end else if (advance && (grant_s != 2'b00)) begin
      last_grant_r <= grant_s[1];
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign grant = grant_s;

endmodule

// File: rtl/regfile_port_sched.sv
// Shares the single-port regfile between the operand-read client (two
// sequential port accesses per request) and the write client. All outputs
// are registered; the regfile's one-cycle read latency is absorbed by
// capturing rf_out one state after each address is presented.
module regfile_port_sched
  import regfile_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  regfile_port_sched_if.slave bus
);

  sched_state_e state_r, state_nxt_s;

  logic [ADDR_W-1:0] addr_b_r, addr_b_nxt_s;
  logic              rd_ack_r, rd_ack_nxt_s;
  logic              rd_done_r, rd_done_nxt_s;
  logic              wr_ack_r, wr_ack_nxt_s;
  logic [ADDR_W-1:0] rf_address_r, rf_address_nxt_s;
  logic              rf_mode_r, rf_mode_nxt_s;
  logic              rf_we_r, rf_we_nxt_s;
  logic [DATA_W-1:0] rf_wdata_r, rf_wdata_nxt_s;
  logic [DATA_W-1:0] rd_data_a_r, rd_data_a_nxt_s;
  logic [DATA_W-1:0] rd_data_b_r, rd_data_b_nxt_s;

  logic [1:0] req_s;
  logic [1:0] grant_s;
  logic       advance_s;

  assign req_s     = {bus.wr_req, bus.rd_req};
  assign advance_s = (state_r == ST_IDLE);

  // Reset value "write granted last" makes the read side win the first tie.
  rr_arb2 #(.RESET_LAST(1'b1)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_s),
    .advance (advance_s),
    .grant   (grant_s)
  );

  // Next state plus next value of every registered output.
  always_comb begin
    state_nxt_s      = state_r;
    addr_b_nxt_s     = addr_b_r;
    rd_ack_nxt_s     = 1'b0;
    rd_done_nxt_s    = 1'b0;
    wr_ack_nxt_s     = 1'b0;
    rf_address_nxt_s = rf_address_r;
    rf_mode_nxt_s    = RF_MODE_READ;
    rf_we_nxt_s      = 1'b0;
    rf_wdata_nxt_s   = rf_wdata_r;
    rd_data_a_nxt_s  = rd_data_a_r;
    rd_data_b_nxt_s  = rd_data_b_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s[REQ_RD]) begin
          // Address A goes to the port right away; B is kept for RD_A->RD_B.
          state_nxt_s      = ST_RD_A;
          addr_b_nxt_s     = bus.rd_addr_b;
          rf_address_nxt_s = bus.rd_addr_a;
          rd_ack_nxt_s     = 1'b1;
        end else if (grant_s[REQ_WR]) begin
          state_nxt_s      = ST_WR;
          rf_address_nxt_s = bus.wr_addr;
          rf_mode_nxt_s    = RF_MODE_WRITE;
          rf_we_nxt_s      = 1'b1;
          rf_wdata_nxt_s   = bus.wr_data;
          wr_ack_nxt_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD_A: begin
        state_nxt_s      = ST_RD_B;
        rf_address_nxt_s = addr_b_r;
      end
      ST_RD_B: begin
        // rf_out now reflects address A presented in RD_A.
        state_nxt_s     = ST_RD_C;
        rd_data_a_nxt_s = bus.rf_out;
      end
      ST_RD_C: begin
        // rf_out now reflects address B presented in RD_B.
        state_nxt_s     = ST_IDLE;
        rd_data_b_nxt_s = bus.rf_out;
        rd_done_nxt_s   = 1'b1;
      end
      ST_WR: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Scheduler state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output and datapath registers; reset clears them so an in-flight write is cut off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_b_r     <= {ADDR_W{1'b0}};
      rd_ack_r     <= 1'b0;
      rd_done_r    <= 1'b0;
      wr_ack_r     <= 1'b0;
      rf_address_r <= {ADDR_W{1'b0}};
      rf_mode_r    <= RF_MODE_READ;
      rf_we_r      <= 1'b0;
      rf_wdata_r   <= {DATA_W{1'b0}};
      rd_data_a_r  <= {DATA_W{1'b0}};
      rd_data_b_r  <= {DATA_W{1'b0}};
    end else begin
      addr_b_r     <= addr_b_nxt_s;
      rd_ack_r     <= rd_ack_nxt_s;
      rd_done_r    <= rd_done_nxt_s;
      wr_ack_r     <= wr_ack_nxt_s;
      rf_address_r <= rf_address_nxt_s;
      rf_mode_r    <= rf_mode_nxt_s;
      rf_we_r      <= rf_we_nxt_s;
      rf_wdata_r   <= rf_wdata_nxt_s;
      rd_data_a_r  <= rd_data_a_nxt_s;
      rd_data_b_r  <= rd_data_b_nxt_s;
    end
  end

  assign bus.rd_ack          = rd_ack_r;
  assign bus.rd_done         = rd_done_r;
  assign bus.rd_data_a       = rd_data_a_r;
  assign bus.rd_data_b       = rd_data_b_r;
  assign bus.wr_ack          = wr_ack_r;
  assign bus.rf_address      = rf_address_r;
  assign bus.rf_mode         = rf_mode_r;
  assign bus.rf_write_enable = rf_we_r;
  assign bus.rf_write_data   = rf_wdata_r;

endmodule

// File: tb/tb_regfile_port_sched.sv
// Bench for regfile_port_sched: behavioural regfile, reference register
// array updated in grant order, and a scoreboard of expected read results.
`timescale 1ns/1ps
module tb_regfile_port_sched;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  regfile_port_sched_if bus ();

  regfile_port_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural single-port regfile: address registered, data out next cycle.
  logic [31:0] rf_mem [32];
  logic [4:0]  rf_addr_q;
  always @(posedge clk) begin
    if (bus.rf_write_enable) rf_mem[bus.rf_address] <= bus.rf_write_data;
    rf_addr_q <= bus.rf_address;
  end
  assign bus.rf_out = rf_mem[rf_addr_q];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no end expected finish before 300000ns");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Reference model: register contents in grant order, round-robin history.
  typedef struct { int due; logic [31:0] a; logic [31:0] b; } rd_exp_t;
  rd_exp_t     exp_q[$];
  logic [31:0] ref_mem [32];
  logic        last_was_wr;

  // Monitor: inputs sampled at the edge, outputs checked 2ns later.
  initial begin
    logic e_rd, e_wr;
    logic [4:0] e_ra, e_rb, e_wa;
    logic [31:0] e_wd;
    rd_exp_t x;
    cyc = 0;
    last_was_wr = 1'b1;
    forever begin
      @(posedge clk);
      e_rd = bus.rd_req; e_wr = bus.wr_req;
      e_ra = bus.rd_addr_a; e_rb = bus.rd_addr_b;
      e_wa = bus.wr_addr; e_wd = bus.wr_data;
      #2;
      cyc++;
      if (!rst) begin
        exp_q.delete();
        last_was_wr = 1'b1;
      end else begin
        chk1("we_only_with_wr_ack", bus.rf_write_enable, bus.wr_ack);
        if (bus.wr_ack) begin
          if (e_rd) chk1("tie_goes_to_write", last_was_wr, 1'b0);
          chk1("wr_mode", bus.rf_mode, 1'b1);
          chk("wr_address", 32'(bus.rf_address), 32'(e_wa));
          chk("wr_data", bus.rf_write_data, e_wd);
          ref_mem[e_wa] = e_wd;
          last_was_wr = 1'b1;
        end
        if (bus.rd_ack) begin
          if (e_wr) chk1("tie_goes_to_read", last_was_wr, 1'b1);
          chk1("rd_mode", bus.rf_mode, 1'b0);
          x.due = cyc + 3; x.a = ref_mem[e_ra]; x.b = ref_mem[e_rb];
          exp_q.push_back(x);
          last_was_wr = 1'b0;
        end
        if (bus.rd_done) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rd_done: got rd_done at cycle %0d expected none", cyc);
          end else begin
            x = exp_q.pop_front();
            chk("rd_done_cycle", 32'(cyc), 32'(x.due));
            chk("rd_data_a", bus.rd_data_a, x.a);
            chk("rd_data_b", bus.rd_data_b, x.b);
          end
        end
      end
    end
  end

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input bit chk_lat);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.wr_addr = a; bus.wr_data = d; bus.wr_req = 1'b1;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk); #2;
      if (bus.wr_ack) lat = n;
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL wr_ack_timeout: got no wr_ack expected one within 20 cycles");
    end else if (chk_lat) begin
      chk("wr_ack_latency", 32'(lat), 32'd1);
    end
    @(negedge clk);
    bus.wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [4:0] b, input bit chk_lat,
                         input bit chk_data, input logic [31:0] exp_a, input logic [31:0] exp_b);
    int lat;
    int dl;
    lat = 0; dl = 0;
    @(negedge clk);
    bus.rd_addr_a = a; bus.rd_addr_b = b; bus.rd_req = 1'b1;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk); #2;
      if (bus.rd_ack) lat = n;
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL rd_ack_timeout: got no rd_ack expected one within 20 cycles");
    end else if (chk_lat) begin
      chk("rd_ack_latency", 32'(lat), 32'd1);
    end
    @(negedge clk);
    bus.rd_req = 1'b0;
    if (chk_data && lat != 0) begin
      for (int n = 1; n <= 10 && dl == 0; n++) begin
        @(posedge clk); #2;
        if (bus.rd_done) dl = n;
      end
      chk("rd_done_after_ack", 32'(dl), 32'd3);
      chk("direct_data_a", bus.rd_data_a, exp_a);
      chk("direct_data_b", bus.rd_data_b, exp_b);
    end
  endtask

  // Back-to-back reads with the request held high across transactions.
  task automatic rd_stream(input int n_tx);
    int lat;
    @(negedge clk);
    for (int i = 0; i < n_tx; i++) begin
      bus.rd_addr_a = 5'($urandom_range(0, 7));
      bus.rd_addr_b = 5'($urandom_range(0, 7));
      bus.rd_req = 1'b1;
      lat = 0;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
        @(posedge clk); #2;
        if (bus.rd_ack) lat = n;
      end
      if (lat == 0) begin
        total++; bad++;
        $display("FAIL rd_stream_timeout: got no rd_ack expected one within 20 cycles");
      end else if (i == 0) begin
        chk("first_tie_read_latency", 32'(lat), 32'd1);
      end
      @(negedge clk);
    end
    bus.rd_req = 1'b0;
  endtask

  // Back-to-back writes with the request held high across transactions.
  task automatic wr_stream(input int n_tx);
    int lat;
    @(negedge clk);
    for (int i = 0; i < n_tx; i++) begin
      bus.wr_addr = 5'($urandom_range(0, 7));
      bus.wr_data = $urandom();
      bus.wr_req = 1'b1;
      lat = 0;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
        @(posedge clk); #2;
        if (bus.wr_ack) lat = n;
      end
      if (lat == 0) begin
        total++; bad++;
        $display("FAIL wr_stream_timeout: got no wr_ack expected one within 20 cycles");
      end else if (i == 0) begin
        // Read wins the first tie (4 cycles), so the write is acked in cycle 5.
        chk("first_tie_write_latency", 32'(lat), 32'd5);
      end
      @(negedge clk);
    end
    bus.wr_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_rd_ack"}, bus.rd_ack, 1'b0);
    chk1({tag, "_rd_done"}, bus.rd_done, 1'b0);
    chk1({tag, "_wr_ack"}, bus.wr_ack, 1'b0);
    chk1({tag, "_rf_we"}, bus.rf_write_enable, 1'b0);
    chk1({tag, "_rf_mode"}, bus.rf_mode, 1'b0);
    chk({tag, "_rf_address"}, 32'(bus.rf_address), 32'd0);
    chk({tag, "_rf_wdata"}, bus.rf_write_data, 32'd0);
    chk({tag, "_rd_data_a"}, bus.rd_data_a, 32'd0);
    chk({tag, "_rd_data_b"}, bus.rd_data_b, 32'd0);
  endtask

  initial begin
    int waited;
    total = 0; bad = 0;
    rst = 1'b0;
    bus.rd_req = 1'b0; bus.rd_addr_a = 5'd0; bus.rd_addr_b = 5'd0;
    bus.wr_req = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = 32'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Fill every register through the scheduler, then place the known values.
    for (int i = 0; i < 32; i++) do_write(5'(i), $urandom(), 1'b1);
    do_write(5'd3, 32'h0000_0011, 1'b1);
    do_write(5'd7, 32'h0000_0022, 1'b1);

    do_read(5'd3, 5'd7, 1'b1, 1'b1, 32'h0000_0011, 32'h0000_0022);
    do_write(5'd5, 32'hDEAD_BEEF, 1'b1);
    do_read(5'd5, 5'd5, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Tie with read granted last: write to R9 goes first, read sees it.
    fork
      do_write(5'd9, 32'h0000_0055, 1'b0);
      do_read(5'd9, 5'd9, 1'b0, 1'b1, 32'h0000_0055, 32'h0000_0055);
    join

    // Reset in RD_B: outputs clear at once, no rd_done follows.
    @(negedge clk);
    bus.rd_addr_a = 5'd3; bus.rd_addr_b = 5'd7; bus.rd_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check_all_zero("rst_in_rd_b");
    bus.rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk1("no_done_after_reset", bus.rd_done, 1'b0);
    end
    do_read(5'd7, 5'd3, 1'b1, 1'b1, 32'h0000_0022, 32'h0000_0011);

    // Reset in WR: write enable drops before the edge, R2 keeps its value.
    do_write(5'd2, 32'h0000_0001, 1'b1);
    @(negedge clk);
    bus.wr_addr = 5'd2; bus.wr_data = 32'h0000_0002; bus.wr_req = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk1("rst_in_wr_we_drop", bus.rf_write_enable, 1'b0);
    chk1("rst_in_wr_ack_drop", bus.wr_ack, 1'b0);
    bus.wr_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_read(5'd2, 5'd2, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0001);

    // Fresh reset, then both clients request continuously with random traffic.
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    fork
      rd_stream(16);
      wr_stream(16);
    join

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk); #3;
      waited++;
    end
    chk("reads_outstanding_at_end", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
